display_scan_ctrl: RTL

Time-multiplexed scan controller for an N-digit 7-segment display sharing a single BCD-to-segment decoder. Latches a packed BCD value through a load/ready handshake, commits it only at frame boundaries (no tearing), and walks the digits with a per-digit slot timer that includes an anti-ghosting blank interval. Drives the decoder's 4-bit `valor` input and the active-low digit enables; sits between the application counters/FSM and the shared decoder.

---
 rtl/display_scan_ctrl_if.sv | 25 ++
 rtl/display_scan_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - load/ready value handshake between application and scan controller
interface display_scan_ctrl_if #(
  parameter int N_DIG = 4
);
  logic                 load;
  logic [4*N_DIG-1:0]   dado;
  logic                 lz_blank;
  logic                 ready;

  // application side: offers values and the suppression mode
  modport master (
    output load,
    output dado,
    output lz_blank,
    input  ready
  );

  // scan controller side
  modport slave (
    input  load,
    input  dado,
    input  lz_blank,
    output ready
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - tear-free multiplexed 7-segment digit scanner with blank interval
module display_scan_ctrl #(
  parameter int N_DIG     = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 2000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  display_scan_ctrl_if.slave         bus,
  output logic [3:0]                 valor,
  output logic [N_DIG-1:0]           an,
  output logic [$clog2(N_DIG)-1:0]   digito
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int DIG_W = $clog2(N_DIG);

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  phase_t             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic [4*N_DIG-1:0] pend_q, pend_d;
  logic [4*N_DIG-1:0] shown_q, shown_d;
  logic               ready_q, ready_d;
  logic [3:0]         valor_d;
  logic [N_DIG-1:0]   an_d;
  logic [N_DIG-1:0]   upper_zero;
  logic [3:0]         nib;
  logic               slot_end;
  logic               frame_end;

  assign slot_end  = (cnt_q == CNT_W'(PRESCALE - 1));
  assign frame_end = slot_end && (dig_q == DIG_W'(N_DIG - 1));

  // Next-state: slot timer, digit walk, handshake and frame-boundary commit.
  // Outputs are computed from the next state so the registered outputs line
  // up with the cnt/dig they describe in the same cycle.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    dig_d   = dig_q;
    pend_d  = pend_q;
    shown_d = shown_q;
    ready_d = ready_q;

    if (slot_end) begin
      dig_d = (dig_q == DIG_W'(N_DIG - 1)) ? '0 : dig_q + 1'b1;
    end

    case (phase_q)
      PH_BLANK: if (cnt_q == CNT_W'(BLANK_CYC - 1)) phase_d = PH_SHOW;
      PH_SHOW:  if (slot_end)                       phase_d = PH_BLANK;
      default:                                      phase_d = PH_BLANK;
    endcase

    // A pending value is only swapped in between frames; while one is
    // waiting, ready stays low so later loads cannot overwrite it.
    if (frame_end && !ready_q) begin
      shown_d = pend_q;
      ready_d = 1'b1;
    end else if (bus.load && ready_q) begin
      pend_d  = bus.dado;
      ready_d = 1'b0;
    end
  end

  // upper_zero[i]: digit i and every digit above it are zero
  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      acc           = acc & (shown_d[4*i +: 4] == 4'd0);
      upper_zero[i] = acc;
    end
  end

  // Digit drive: lit only in the show phase, for a valid BCD nibble that is
  // not a suppressed leading zero; otherwise the decoder gets the blank code.
  always_comb begin
    nib     = shown_d[{dig_d, 2'b00} +: 4];
    valor_d = 4'hF;
    an_d    = '1;
    if ((phase_d == PH_SHOW) && (nib <= 4'd9) &&
        !(bus.lz_blank && (dig_d != '0) && upper_zero[dig_d])) begin
      valor_d = nib;
      an_d    = ~(N_DIG'(1) << dig_d);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_BLANK;
      cnt_q   <= '0;
      dig_q   <= '0;
      pend_q  <= '0;
      shown_q <= '0;
      ready_q <= 1'b1;
      valor   <= 4'hF;
      an      <= '1;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      pend_q  <= pend_d;
      shown_q <= shown_d;
      ready_q <= ready_d;
      valor   <= valor_d;
      an      <= an_d;
    end
  end

  assign digito    = dig_q;
  assign bus.ready = ready_q;

endmodule
